// File: rtl/superscalar_execute_pipe.sv
// Superscalar execute stage: NUM_FU parallel ALU/shifter lanes, each with a
// combinational branch check (E1) followed by a one-entry result register (E2).
// A shared redirect unit picks the oldest mispredicting branch by ROB age and
// suppresses younger redirects until the next flush.
//
// Handshake (both directions, per lane): a transfer happens on a rising edge
// where valid && ready are both high. The producer holds valid and its payload
// stable until that edge. Toward the reservation stations:
// issue_ready = !cdb_valid || cdb_ready, so a lane accepts a new op whenever
// its held result is absent or is being drained in the same cycle.
//
// ALU function select: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL,
// 7 SRA, 8 OR, 9 AND, 10 pass B, others pass A.
// Branch select: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 JAL, 7 JALR.
module superscalar_execute_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FU     = 3,
  parameter int PHYS_W     = 6,
  parameter int ROB_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [ROB_W-1:0]             rob_head,
  input  logic [NUM_FU-1:0]            issue_valid,
  output logic [NUM_FU-1:0]            issue_ready,
  input  logic [NUM_FU*DATA_WIDTH-1:0] issue_data_a,
  input  logic [NUM_FU*DATA_WIDTH-1:0] issue_data_b,
  input  logic [NUM_FU*4-1:0]          issue_func_sel,
  input  logic [NUM_FU*3-1:0]          issue_branch_sel,
  input  logic [NUM_FU-1:0]            issue_pred_taken,
  input  logic [NUM_FU*DATA_WIDTH-1:0] issue_pred_target,
  input  logic [NUM_FU*DATA_WIDTH-1:0] issue_alt_pc,
  input  logic [NUM_FU*DATA_WIDTH-1:0] issue_link_pc,
  input  logic [NUM_FU-1:0]            issue_save_pc,
  input  logic [NUM_FU*PHYS_W-1:0]     issue_rd_phys,
  input  logic [NUM_FU*ROB_W-1:0]      issue_rob_idx,
  output logic [NUM_FU-1:0]            cdb_valid,
  input  logic [NUM_FU-1:0]            cdb_ready,
  output logic [NUM_FU*DATA_WIDTH-1:0] cdb_data,
  output logic [NUM_FU*PHYS_W-1:0]     cdb_rd_phys,
  output logic [NUM_FU*ROB_W-1:0]      cdb_rob_idx,
  output logic [NUM_FU-1:0]            cdb_mispredict,
  output logic [NUM_FU*DATA_WIDTH-1:0] cdb_correct_pc,
  output logic                         redirect_valid,
  output logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic [ROB_W-1:0]             redirect_rob_idx,
  output logic [NUM_FU-1:0]            bp_update_valid,
  output logic [NUM_FU-1:0]            bp_update_taken,
  output logic [NUM_FU*DATA_WIDTH-1:0] bp_update_pc
);

  localparam int DW  = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);
  // PCs are word aligned: the two low bits are always forced to zero.
  localparam logic [DW-1:0] ALIGN_MASK = {{(DW-2){1'b1}}, 2'b00};

  // E1 combinational results
  logic [NUM_FU-1:0][DW-1:0] res_val;
  logic [NUM_FU-1:0][DW-1:0] corr_pc;
  logic [NUM_FU-1:0]         mpc;
  logic [NUM_FU-1:0]         is_cond;
  logic [NUM_FU-1:0]         mispred;
  logic [NUM_FU-1:0]         cap;

  // E2 lane registers
  logic [NUM_FU-1:0]             cdb_valid_q, cdb_valid_d;
  logic [NUM_FU-1:0][DW-1:0]     cdb_data_q, cdb_data_d;
  logic [NUM_FU-1:0][PHYS_W-1:0] cdb_rd_phys_q, cdb_rd_phys_d;
  logic [NUM_FU-1:0][ROB_W-1:0]  cdb_rob_idx_q, cdb_rob_idx_d;
  logic [NUM_FU-1:0]             cdb_mispredict_q, cdb_mispredict_d;
  logic [NUM_FU-1:0][DW-1:0]     cdb_correct_pc_q, cdb_correct_pc_d;
  logic [NUM_FU-1:0]             bp_update_valid_q, bp_update_valid_d;
  logic [NUM_FU-1:0]             bp_update_taken_q, bp_update_taken_d;
  logic [NUM_FU-1:0][DW-1:0]     bp_update_pc_q, bp_update_pc_d;

  // Redirect unit registers
  logic             redirect_valid_q, redirect_valid_d;
  logic [DW-1:0]    redirect_pc_q, redirect_pc_d;
  logic             pending_q, pending_d;
  logic [ROB_W-1:0] pend_idx_q, pend_idx_d;

  // Redirect candidate selection
  logic             cand_found;
  logic [ROB_W-1:0] cand_idx;
  logic [ROB_W-1:0] cand_age;
  logic [DW-1:0]    cand_pc;
  logic [ROB_W-1:0] pend_age;
  logic             fire;

  assign issue_ready = ~cdb_valid_q | cdb_ready;
  assign cap         = issue_valid & issue_ready & {NUM_FU{~flush}};

  // E1: per-lane ALU/shifter and branch controller
  always_comb begin
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    logic [DW-1:0]  alu;
    logic [DW-1:0]  ptgt;
    logic [DW-1:0]  jalr_tgt;
    logic [3:0]     fsel;
    logic [2:0]     bsel;
    logic [SHW-1:0] shamt;
    op_a     = '0;
    op_b     = '0;
    alu      = '0;
    ptgt     = '0;
    jalr_tgt = '0;
    fsel     = '0;
    bsel     = '0;
    shamt    = '0;
    res_val  = '0;
    corr_pc  = '0;
    mpc      = '0;
    is_cond  = '0;
    mispred  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      op_a  = issue_data_a[i*DW +: DW];
      op_b  = issue_data_b[i*DW +: DW];
      ptgt  = issue_pred_target[i*DW +: DW];
      fsel  = issue_func_sel[i*4 +: 4];
      bsel  = issue_branch_sel[i*3 +: 3];
      shamt = op_b[SHW-1:0];
      case (fsel)
        4'd0:    alu = op_a + op_b;
        4'd1:    alu = op_a - op_b;
        4'd2:    alu = op_a << shamt;
        4'd3:    alu = {{(DW-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        4'd4:    alu = {{(DW-1){1'b0}}, op_a < op_b};
        4'd5:    alu = op_a ^ op_b;
        4'd6:    alu = op_a >> shamt;
        4'd7:    alu = $unsigned($signed(op_a) >>> shamt);
        4'd8:    alu = op_a | op_b;
        4'd9:    alu = op_a & op_b;
        4'd10:   alu = op_b;
        default: alu = op_a;
      endcase
      case (bsel)
        3'd1:    mpc[i] = (op_a == op_b);
        3'd2:    mpc[i] = (op_a != op_b);
        3'd3:    mpc[i] = ($signed(op_a) < $signed(op_b));
        3'd4:    mpc[i] = !($signed(op_a) < $signed(op_b));
        3'd5:    mpc[i] = (op_a < op_b);
        3'd6:    mpc[i] = 1'b1;
        3'd7:    mpc[i] = 1'b1;
        default: mpc[i] = 1'b0;
      endcase
      is_cond[i] = (bsel != 3'd0) && (bsel < 3'd6);
      jalr_tgt   = alu & ALIGN_MASK;
      if (bsel == 3'd7) begin
        mispred[i] = (jalr_tgt != ptgt);
        corr_pc[i] = jalr_tgt;
      end else begin
        mispred[i] = is_cond[i] && (mpc[i] ^ issue_pred_taken[i]);
        corr_pc[i] = issue_alt_pc[i*DW +: DW] & ALIGN_MASK;
      end
      if (is_cond[i]) begin
        res_val[i] = ptgt;
      end else if (issue_save_pc[i]) begin
        res_val[i] = issue_link_pc[i*DW +: DW] & ALIGN_MASK;
      end else begin
        res_val[i] = alu;
      end
    end
  end

  // E2: per-lane output register next state (capture, hold, drain, flush)
  always_comb begin
    cdb_valid_d       = cdb_valid_q;
    cdb_data_d        = cdb_data_q;
    cdb_rd_phys_d     = cdb_rd_phys_q;
    cdb_rob_idx_d     = cdb_rob_idx_q;
    cdb_mispredict_d  = cdb_mispredict_q;
    cdb_correct_pc_d  = cdb_correct_pc_q;
    bp_update_valid_d = '0;
    bp_update_taken_d = bp_update_taken_q;
    bp_update_pc_d    = bp_update_pc_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (flush) begin
        cdb_valid_d[i] = 1'b0;
      end else if (cap[i]) begin
        cdb_valid_d[i]      = 1'b1;
        cdb_data_d[i]       = res_val[i];
        cdb_rd_phys_d[i]    = issue_rd_phys[i*PHYS_W +: PHYS_W];
        cdb_rob_idx_d[i]    = issue_rob_idx[i*ROB_W +: ROB_W];
        cdb_mispredict_d[i] = mispred[i];
        cdb_correct_pc_d[i] = corr_pc[i];
        if (is_cond[i]) begin
          bp_update_valid_d[i] = 1'b1;
          bp_update_taken_d[i] = mpc[i];
          bp_update_pc_d[i]    = issue_pred_target[i*DW +: DW];
        end
      end else if (cdb_ready[i]) begin
        cdb_valid_d[i] = 1'b0;
      end
    end
  end

  // Redirect unit: oldest capturing mispredict wins, gated by the pending one
  always_comb begin
    logic [ROB_W-1:0] age;
    age        = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_age   = '0;
    cand_pc    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      age = issue_rob_idx[i*ROB_W +: ROB_W] - rob_head;
      if (cap[i] && mispred[i] && (!cand_found || age < cand_age)) begin
        cand_found = 1'b1;
        cand_idx   = issue_rob_idx[i*ROB_W +: ROB_W];
        cand_age   = age;
        cand_pc    = corr_pc[i];
      end
    end
    pend_age         = pend_idx_q - rob_head;
    fire             = cand_found && (!pending_q || cand_age < pend_age);
    redirect_valid_d = fire;
    redirect_pc_d    = fire ? cand_pc : redirect_pc_q;
    pend_idx_d       = fire ? cand_idx : pend_idx_q;
    pending_d        = flush ? 1'b0 : (pending_q | fire);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q       <= '0;
      cdb_data_q        <= '0;
      cdb_rd_phys_q     <= '0;
      cdb_rob_idx_q     <= '0;
      cdb_mispredict_q  <= '0;
      cdb_correct_pc_q  <= '0;
      bp_update_valid_q <= '0;
      bp_update_taken_q <= '0;
      bp_update_pc_q    <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_pc_q     <= '0;
      pending_q         <= 1'b0;
      pend_idx_q        <= '0;
    end else begin
      cdb_valid_q       <= cdb_valid_d;
      cdb_data_q        <= cdb_data_d;
      cdb_rd_phys_q     <= cdb_rd_phys_d;
      cdb_rob_idx_q     <= cdb_rob_idx_d;
      cdb_mispredict_q  <= cdb_mispredict_d;
      cdb_correct_pc_q  <= cdb_correct_pc_d;
      bp_update_valid_q <= bp_update_valid_d;
      bp_update_taken_q <= bp_update_taken_d;
      bp_update_pc_q    <= bp_update_pc_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_pc_q     <= redirect_pc_d;
      pending_q         <= pending_d;
      pend_idx_q        <= pend_idx_d;
    end
  end

  assign cdb_valid        = cdb_valid_q;
  assign cdb_data         = cdb_data_q;
  assign cdb_rd_phys      = cdb_rd_phys_q;
  assign cdb_rob_idx      = cdb_rob_idx_q;
  assign cdb_mispredict   = cdb_mispredict_q;
  assign cdb_correct_pc   = cdb_correct_pc_q;
  assign bp_update_valid  = bp_update_valid_q;
  assign bp_update_taken  = bp_update_taken_q;
  assign bp_update_pc     = bp_update_pc_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign redirect_rob_idx = pend_idx_q;

endmodule

// File: tb/tb_superscalar_execute_pipe.sv
// Directed bench for superscalar_execute_pipe: ALU ops, handshake and
// backpressure, branch resolution, oldest-first redirect, flush and reset.
module tb_superscalar_execute_pipe;

  localparam int DW  = 32;
  localparam int NF  = 3;
  localparam int PW  = 6;
  localparam int RW  = 5;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [RW-1:0]     rob_head;
  logic [NF-1:0]     issue_valid;
  logic [NF-1:0]     issue_ready;
  logic [NF*DW-1:0]  issue_data_a;
  logic [NF*DW-1:0]  issue_data_b;
  logic [NF*4-1:0]   issue_func_sel;
  logic [NF*3-1:0]   issue_branch_sel;
  logic [NF-1:0]     issue_pred_taken;
  logic [NF*DW-1:0]  issue_pred_target;
  logic [NF*DW-1:0]  issue_alt_pc;
  logic [NF*DW-1:0]  issue_link_pc;
  logic [NF-1:0]     issue_save_pc;
  logic [NF*PW-1:0]  issue_rd_phys;
  logic [NF*RW-1:0]  issue_rob_idx;
  logic [NF-1:0]     cdb_valid;
  logic [NF-1:0]     cdb_ready;
  logic [NF*DW-1:0]  cdb_data;
  logic [NF*PW-1:0]  cdb_rd_phys;
  logic [NF*RW-1:0]  cdb_rob_idx;
  logic [NF-1:0]     cdb_mispredict;
  logic [NF*DW-1:0]  cdb_correct_pc;
  logic              redirect_valid;
  logic [DW-1:0]     redirect_pc;
  logic [RW-1:0]     redirect_rob_idx;
  logic [NF-1:0]     bp_update_valid;
  logic [NF-1:0]     bp_update_taken;
  logic [NF*DW-1:0]  bp_update_pc;

  int n_cmp;
  int n_err;
  logic [DW-1:0] exp_q[$];

  superscalar_execute_pipe #(
    .DATA_WIDTH(DW), .NUM_FU(NF), .PHYS_W(PW), .ROB_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_data_a(issue_data_a), .issue_data_b(issue_data_b),
    .issue_func_sel(issue_func_sel), .issue_branch_sel(issue_branch_sel),
    .issue_pred_taken(issue_pred_taken), .issue_pred_target(issue_pred_target),
    .issue_alt_pc(issue_alt_pc), .issue_link_pc(issue_link_pc),
    .issue_save_pc(issue_save_pc), .issue_rd_phys(issue_rd_phys),
    .issue_rob_idx(issue_rob_idx),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_data(cdb_data),
    .cdb_rd_phys(cdb_rd_phys), .cdb_rob_idx(cdb_rob_idx),
    .cdb_mispredict(cdb_mispredict), .cdb_correct_pc(cdb_correct_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_rob_idx(redirect_rob_idx),
    .bp_update_valid(bp_update_valid), .bp_update_taken(bp_update_taken),
    .bp_update_pc(bp_update_pc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_w(input logic [NF*DW-1:0] v, input int l);
    return v[l*DW +: DW];
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_issue();
    issue_valid       = '0;
    issue_data_a      = '0;
    issue_data_b      = '0;
    issue_func_sel    = '0;
    issue_branch_sel  = '0;
    issue_pred_taken  = '0;
    issue_pred_target = '0;
    issue_alt_pc      = '0;
    issue_link_pc     = '0;
    issue_save_pc     = '0;
    issue_rd_phys     = '0;
    issue_rob_idx     = '0;
  endtask

  task automatic drive(input int l, input logic [3:0] fsel, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [2:0] bsel,
                       input logic pt, input logic [DW-1:0] ptgt,
                       input logic [DW-1:0] alt, input logic [DW-1:0] link,
                       input logic save, input logic [PW-1:0] rd,
                       input logic [RW-1:0] rob);
    issue_valid[l]                = 1'b1;
    issue_func_sel[l*4 +: 4]      = fsel;
    issue_data_a[l*DW +: DW]      = a;
    issue_data_b[l*DW +: DW]      = b;
    issue_branch_sel[l*3 +: 3]    = bsel;
    issue_pred_taken[l]           = pt;
    issue_pred_target[l*DW +: DW] = ptgt;
    issue_alt_pc[l*DW +: DW]      = alt;
    issue_link_pc[l*DW +: DW]     = link;
    issue_save_pc[l]              = save;
    issue_rd_phys[l*PW +: PW]     = rd;
    issue_rob_idx[l*RW +: RW]     = rob;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ALU vectors: func, a, b, expected result
  logic [3:0]    v_f[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic [DW-1:0] v_a[10] = '{32'd5, 32'd10, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hF0, 32'h8000_0000, 32'h8000_0000, 32'hF0, 32'hF0};
  logic [DW-1:0] v_b[10] = '{32'd7, 32'd3, 32'd4, 32'd0, 32'd0,
                             32'hFF, 32'd4, 32'd4, 32'h0F, 32'h3C};
  logic [DW-1:0] v_e[10] = '{32'd12, 32'd7, 32'd16, 32'd1, 32'd0,
                             32'h0F, 32'h0800_0000, 32'hF800_0000, 32'hFF, 32'h30};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    rob_head  = '0;
    cdb_ready = '1;
    clear_issue();
    #12;
    // Reset state
    check("rst_issue_ready", 64'(issue_ready), 64'h7);
    check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("rst_redirect", 64'(redirect_valid), 64'h0);
    check("rst_data", 64'(lane_w(cdb_data, 1)), 64'h0);
    rst_n = 1'b1;
    tick();

    // ADD on lane 1
    drive(1, 4'd0, 32'd5, 32'd7, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 6'd12, 5'd3);
    #1;
    check("add_ready_before", 64'(issue_ready[1]), 64'h1);
    tick();
    clear_issue();
    check("add_valid", 64'(cdb_valid), 64'h2);
    check("add_data", 64'(lane_w(cdb_data, 1)), 64'd12);
    check("add_rd", 64'(cdb_rd_phys[1*PW +: PW]), 64'd12);
    check("add_rob", 64'(cdb_rob_idx[1*RW +: RW]), 64'd3);
    check("add_ready_after", 64'(issue_ready[1]), 64'h1);
    check("add_no_redirect", 64'(redirect_valid), 64'h0);

    // ALU function table on lane 0, back-to-back with no bubble
    for (int k = 0; k < 10; k++) begin
      drive(0, v_f[k], v_a[k], v_b[k], 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 6'(k), 5'(k));
      tick();
      check($sformatf("alu_valid_%0d", k), 64'(cdb_valid[0]), 64'h1);
      check($sformatf("alu_data_%0d", k), 64'(lane_w(cdb_data, 0)), 64'(v_e[k]));
    end
    clear_issue();
    tick();
    check("alu_drained", 64'(cdb_valid), 64'h0);

    // Backpressure on lane 0
    cdb_ready[0] = 1'b0;
    drive(0, 4'd0, 32'd1, 32'd1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 6'd1, 5'd1);
    exp_q.push_back(32'd2);
    tick();
    drive(0, 4'd0, 32'd3, 32'd4, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 6'd2, 5'd2);
    exp_q.push_back(32'd7);
    begin
      logic [DW-1:0] held;
      held = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        #1;
        check($sformatf("bp_ready_%0d", k), 64'(issue_ready[0]), 64'h0);
        check($sformatf("bp_valid_%0d", k), 64'(cdb_valid[0]), 64'h1);
        check($sformatf("bp_data_%0d", k), 64'(lane_w(cdb_data, 0)), 64'(held));
        check($sformatf("bp_rob_%0d", k), 64'(cdb_rob_idx[0 +: RW]), 64'd1);
        tick();
      end
    end
    cdb_ready[0] = 1'b1;
    #1;
    check("bp_release_ready", 64'(issue_ready[0]), 64'h1);
    tick();
    clear_issue();
    check("bp_next_valid", 64'(cdb_valid[0]), 64'h1);
    check("bp_next_data", 64'(lane_w(cdb_data, 0)), 64'(exp_q.pop_front()));
    tick();

    // BEQ on lane 2 mispredicted not-taken
    drive(2, 4'd0, 32'd9, 32'd9, 3'd1, 1'b0, 32'h200, 32'h140, 32'h0, 1'b0, 6'd3, 5'd5);
    tick();
    clear_issue();
    check("beq_mispredict", 64'(cdb_mispredict[2]), 64'h1);
    check("beq_correct_pc", 64'(lane_w(cdb_correct_pc, 2)), 64'h140);
    check("beq_data", 64'(lane_w(cdb_data, 2)), 64'h200);
    check("beq_redirect_v", 64'(redirect_valid), 64'h1);
    check("beq_redirect_pc", 64'(redirect_pc), 64'h140);
    check("beq_redirect_rob", 64'(redirect_rob_idx), 64'd5);
    check("beq_bp_valid", 64'(bp_update_valid), 64'h4);
    check("beq_bp_taken", 64'(bp_update_taken[2]), 64'h1);
    check("beq_bp_pc", 64'(lane_w(bp_update_pc, 2)), 64'h200);
    tick();
    check("beq_redirect_pulse", 64'(redirect_valid), 64'h0);
    check("beq_bp_pulse", 64'(bp_update_valid), 64'h0);

    // Flush together with issue: nothing captured
    drive(0, 4'd0, 32'd1, 32'd2, 3'd1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 6'd1, 5'd1);
    do_flush();
    clear_issue();
    check("flush_cdb_valid", 64'(cdb_valid), 64'h0);
    check("flush_bp_valid", 64'(bp_update_valid), 64'h0);
    check("flush_redirect", 64'(redirect_valid), 64'h0);

    // Same-cycle mispredicts, oldest by age wins
    rob_head = 5'd30;
    drive(0, 4'd0, 32'd1, 32'd1, 3'd2, 1'b1, 32'h0, 32'h300, 32'h0, 1'b0, 6'd4, 5'd2);
    drive(2, 4'd0, 32'd6, 32'd6, 3'd1, 1'b0, 32'h0, 32'h400, 32'h0, 1'b0, 6'd5, 5'd31);
    tick();
    clear_issue();
    check("age_mispredict", 64'(cdb_mispredict & cdb_valid), 64'h5);
    check("age_redirect_v", 64'(redirect_valid), 64'h1);
    check("age_redirect_rob", 64'(redirect_rob_idx), 64'd31);
    check("age_redirect_pc", 64'(redirect_pc), 64'h400);
    drive(1, 4'd0, 32'd2, 32'd2, 3'd1, 1'b0, 32'h0, 32'h500, 32'h0, 1'b0, 6'd6, 5'd4);
    tick();
    clear_issue();
    check("young_redirect_v", 64'(redirect_valid), 64'h0);
    check("young_cdb_valid", 64'(cdb_valid[1]), 64'h1);
    check("young_cdb_mp", 64'(cdb_mispredict[1]), 64'h1);
    check("young_rob_kept", 64'(redirect_rob_idx), 64'd31);
    do_flush();
    rob_head = '0;

    // JALR with link save
    drive(0, 4'd0, 32'h1003, 32'h0, 3'd7, 1'b1, 32'h2000, 32'h0, 32'h44, 1'b1, 6'd7, 5'd7);
    tick();
    clear_issue();
    check("jalr_data", 64'(lane_w(cdb_data, 0)), 64'h44);
    check("jalr_correct_pc", 64'(lane_w(cdb_correct_pc, 0)), 64'h1000);
    check("jalr_mispredict", 64'(cdb_mispredict[0]), 64'h1);
    check("jalr_redirect_v", 64'(redirect_valid), 64'h1);
    check("jalr_redirect_pc", 64'(redirect_pc), 64'h1000);
    check("jalr_no_bp", 64'(bp_update_valid), 64'h0);
    do_flush();

    // Asynchronous reset in the middle of a stall
    cdb_ready[1] = 1'b0;
    drive(1, 4'd0, 32'd20, 32'd22, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 6'd9, 5'd9);
    tick();
    clear_issue();
    check("stall_valid", 64'(cdb_valid[1]), 64'h1);
    check("stall_data", 64'(lane_w(cdb_data, 1)), 64'd42);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'h0);
    check("arst_data", 64'(lane_w(cdb_data, 1)), 64'h0);
    check("arst_ready", 64'(issue_ready), 64'h7);
    #5;
    rst_n = 1'b1;
    cdb_ready = '1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/superscalar_execute_pipe.md
# superscalar_execute_pipe

Parametrised, registered successor to the 3-wide execute stage. It holds NUM_FU parallel ALU/shifter lanes, each with a one-entry output register and a valid/ready handshake toward the CDB arbiter. Branch resolution is centralised: the oldest mispredicting branch by ROB age produces a single redirect, and younger redirects are suppressed until the next flush. The block sits between the reservation stations and the CDB/ROB/branch-predictor update path.

## Interface
- DATA_WIDTH, 32, operand/result width
- NUM_FU, 3, lane count (1..8)
- PHYS_W, 6, physical register tag width
- ROB_W, 5, ROB index width; age = (rob_idx - rob_head) mod 2^ROB_W
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush from commit
- rob_head  in  ROB_W  current ROB head index
- issue_valid / issue_ready  in / out  NUM_FU  per-lane issue handshake
- issue_data_a, issue_data_b  in  NUM_FU*DATA_WIDTH  operands
- issue_func_sel  in  NUM_FU*4  ALU function select
- issue_branch_sel  in  NUM_FU*3  0 none, 1-5 conditional, 6 JAL, 7 JALR
- issue_pred_taken  in  NUM_FU  predicted direction
- issue_pred_target  in  NUM_FU*DATA_WIDTH  predicted next PC
- issue_alt_pc  in  NUM_FU*DATA_WIDTH  address of the non-predicted path
- issue_link_pc, issue_save_pc  in  NUM_FU*DATA_WIDTH, NUM_FU  return address and its write-select
- issue_rd_phys, issue_rob_idx  in  NUM_FU*PHYS_W, NUM_FU*ROB_W  destination tags
- cdb_valid / cdb_ready  out / in  NUM_FU  per-lane result handshake
- cdb_data, cdb_rd_phys, cdb_rob_idx  out  per lane  result and tags
- cdb_mispredict, cdb_correct_pc  out  NUM_FU, NUM_FU*DATA_WIDTH  branch outcome
- redirect_valid, redirect_pc, redirect_rob_idx  out  1, DATA_WIDTH, ROB_W  front-end redirect
- bp_update_valid, bp_update_taken, bp_update_pc  out  NUM_FU, NUM_FU, NUM_FU*DATA_WIDTH  predictor training

## Operation
- E1, combinational per lane: one function_unit_alu_shifter and one Branch_Controller per lane produce result, MPC and JALR.
- Mispredict: JALR → {result[DW-1:2],2'b00} != pred_target. Conditional → MPC ^ pred_taken. Otherwise 0.
- correct_pc: JALR → {result[DW-1:2],2'b00}. Otherwise {alt_pc[DW-1:2],2'b00}.
- Result value: conditional branch → pred_target. Else if save_pc → {link_pc[DW-1:2],2'b00}. Else the ALU result.
- E2: per-lane output register. A lane captures when issue_valid && issue_ready && !flush.
- issue_ready[i] = !cdb_valid[i] || cdb_ready[i]. The register holds stable while cdb_valid is high and cdb_ready is low.
- bp_update_valid[i] pulses for exactly 1 cycle after a conditional branch is captured, independent of cdb_ready. bp_update_taken = MPC, bp_update_pc = pred_target.
- Redirect unit: among the lanes capturing this cycle with mispredict set, select the smallest age. It fires if no redirect is pending, or if the candidate's age is smaller than the pending redirect's age recomputed against the current rob_head.
  - On fire: redirect_valid pulses 1 cycle and the pending index is stored.
  - Younger mispredicts are suppressed but still reported on the CDB.
- flush: the next edge clears every cdb_valid, bp_update_valid, redirect_valid and the pending state. Issue is ignored while flush=1. issue_ready still follows the handshake rule.

## Timing
- Latency: issue accept at edge N → cdb_valid, bp_update_valid and redirect_valid at N+1.
- Throughput: one instruction per lane per cycle while cdb_ready=1.
- Reset: all valids, pending flag, data, PCs and tags are 0. issue_ready = 1 for every lane.
- Reset asserted mid-operation: state clears immediately (asynchronous). In-flight results are discarded.
- Simultaneous capture into a lane whose held result drains in the same cycle (cdb_ready=1): the new entry replaces the old one, with no bubble.
- Same-cycle flush and issue: flush wins and nothing is captured.

## Test plan
- ADD on lane 1: a=5, b=7, rd=12, rob=3 → next cycle cdb_valid[1]=1, data=12, rd_phys=12, rob_idx=3. issue_ready[1] stays 1.
- Backpressure: lane 0 holds cdb_ready=0 for 3 cycles with issue_valid=1 → issue_ready[0]=0, cdb outputs stable. Release → next instruction appears one cycle later.
- BEQ on lane 2: a=b=9, pred_taken=0, alt_pc=0x140 → cdb_mispredict=1, correct_pc=0x140, redirect 0x140, bp_update_taken=1.
- Same-cycle mispredicts with rob_head=30, rob_idx 2 (lane 0) and 31 (lane 2) → redirect_rob_idx=31 only. A later mispredict at rob 4 raises no redirect.
- JALR: a=0x1003, b=0, pred_target=0x2000, save_pc, link_pc=0x44 → data=0x44, correct_pc=0x1000, redirect_valid=1.
- Flush and reset: flush asserted alongside an issue → nothing captured, all valids 0 next cycle. rst_n low mid-stall → outputs 0 immediately.
